// File: rtl/parity_frame_tx.sv
// Serial transmitter for the even/odd-parity link. Each frame is a start bit, the data
// LSB-first, one parity bit and a stop bit, with every bit held for CLKS_PER_BIT cycles.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | line high, ready for a new word
// START   | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA    | shift-register bit 0 on tx, shifted every CLKS_PER_BIT cycles
// PARITY  | parity bit on tx for CLKS_PER_BIT cycles
// STOP    | stop bit (tx=1); done pulses in its last cycle
module parity_frame_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              p_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              p_q, p_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              cyc_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        p_d      = p_q;
        cyc_last = (cyc_q == CYC_LAST);

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_START;
                    shift_d = data_in;
                    p_d     = (ODD_PARITY != 0) ? ~(^data_in) : (^data_in);
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (cyc_last) begin
                    cyc_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cyc_last) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_PARITY;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (cyc_last) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cyc_last) begin
                    cyc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase

        // tx and done are registered, so they are decoded from the next-state values
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = p_d;
            default:  tx_d = 1'b1;
        endcase
        done_d = (state_d == S_STOP) && (cyc_d == CYC_LAST);
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = ~ready;
    assign tx    = tx_q;
    assign p_out = p_q;
    assign done  = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three instances (even/4 clk per bit, odd/4, even/1) checked
// against a frame model built from the link's bit order and parity rule.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] data_m = '0, data_o = '0, data_f = '0;
    logic       valid_m = 1'b0, valid_o = 1'b0, valid_f = 1'b0;
    logic       ready_m, tx_m, p_m, busy_m, done_m;
    logic       ready_o, tx_o, p_o, busy_o, done_o;
    logic       ready_f, tx_f, p_f, busy_f, done_f;

    int sel = 0;
    logic o_ready, o_tx, o_p, o_busy, o_done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .ODD_PARITY(0)) dut_main (
        .clk(clk), .rst(rst), .data_in(data_m), .valid(valid_m), .ready(ready_m),
        .tx(tx_m), .p_out(p_m), .busy(busy_m), .done(done_m));

    parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst(rst), .data_in(data_o), .valid(valid_o), .ready(ready_o),
        .tx(tx_o), .p_out(p_o), .busy(busy_o), .done(done_o));

    parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .ODD_PARITY(0)) dut_fast (
        .clk(clk), .rst(rst), .data_in(data_f), .valid(valid_f), .ready(ready_f),
        .tx(tx_f), .p_out(p_f), .busy(busy_f), .done(done_f));

    always_comb begin
        o_ready = ready_m; o_tx = tx_m; o_p = p_m; o_busy = busy_m; o_done = done_m;
        case (sel)
            1: begin o_ready = ready_o; o_tx = tx_o; o_p = p_o; o_busy = busy_o; o_done = done_o; end
            2: begin o_ready = ready_f; o_tx = tx_f; o_p = p_f; o_busy = busy_f; o_done = done_f; end
            default: ;
        endcase
    end

    // Reference: parity from a count of ones; frame = start, data LSB-first, parity, stop.
    function automatic logic model_parity(input logic [3:0] d, input bit odd);
        int ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(d[i]);
        return logic'((ones % 2 == 1) != odd);
    endfunction

    function automatic logic [6:0] model_frame(input logic [3:0] d, input bit odd);
        logic [6:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 4; i++) f[1+i] = d[i];
        f[5] = model_parity(d, odd);
        f[6] = 1'b1;
        return f;
    endfunction

    task automatic drive(input int s, input logic v, input logic [3:0] d);
        case (s)
            0: begin valid_m = v; data_m = d; end
            1: begin valid_o = v; data_o = d; end
            default: begin valid_f = v; data_f = d; end
        endcase
    endtask

    // Sends one word on instance s and checks the whole frame plus the idle cycle after it.
    task automatic send_frame(input int s, input int cpb, input bit odd, input logic [3:0] d);
        logic [27:0] obs, expv;
        logic [6:0]  bits;
        logic        exp_p, rp;
        logic [3:0]  rd;
        int          done_at, done_cnt, nbits;
        bit          p_bad, busy_bad;
        sel = s;
        exp_p = model_parity(d, odd);
        bits = model_frame(d, odd);
        obs = '0; expv = '0; done_at = -1; done_cnt = 0; p_bad = 0; busy_bad = 0;
        nbits = 7 * cpb;
        @(negedge clk);
        n_total++;
        if (o_ready !== 1'b1) $display("FAIL pre_ready s=%0d: got %b want 1", s, o_ready);
        else n_pass++;
        drive(s, 1'b1, d);
        @(posedge clk);
        #1 drive(s, 1'b0, 4'($urandom));
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            obs[k]  = o_tx;
            expv[k] = bits[k/cpb];
            if (o_done === 1'b1) begin done_cnt++; done_at = k; end
            if (o_p !== exp_p) p_bad = 1;
            if (o_busy !== 1'b1) busy_bad = 1;
        end
        n_total++;
        if (obs !== expv) $display("FAIL tx_stream s=%0d d=%h: got %h want %h", s, d, obs, expv);
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || done_at != nbits - 1)
            $display("FAIL done_pulse s=%0d d=%h: got count %0d at cycle %0d want 1 at %0d",
                     s, d, done_cnt, done_at + 1, nbits);
        else n_pass++;
        n_total++;
        if (p_bad) $display("FAIL p_out s=%0d d=%h: not held at %b", s, d, exp_p);
        else n_pass++;
        n_total++;
        if (busy_bad) $display("FAIL busy s=%0d d=%h: dropped during frame", s, d);
        else n_pass++;
        for (int i = 0; i < 4; i++) rd[i] = obs[(1+i)*cpb + cpb/2];
        rp = obs[5*cpb + cpb/2];
        n_total++;
        if ((^{rd, rp}) !== logic'(odd))
            $display("FAIL checker_xor s=%0d d=%h: got %b want %b", s, d, ^{rd, rp}, odd);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (o_ready !== 1'b1 || o_tx !== 1'b1)
            $display("FAIL post_idle s=%0d: got ready=%b tx=%b want 1 1", s, o_ready, o_tx);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b1, 4'($urandom));
        drive(1, 1'b1, 4'($urandom));
        drive(2, 1'b1, 4'($urandom));
        repeat (2) @(negedge clk);
        n_total++;
        if ({tx_m, ready_m, busy_m, done_m, p_m} !== 5'b11000)
            $display("FAIL reset_main: got tx,rdy,busy,done,p=%b want 11000",
                     {tx_m, ready_m, busy_m, done_m, p_m});
        else n_pass++;
        n_total++;
        if ({tx_o, ready_o, busy_o, done_o, tx_f, ready_f, busy_f, done_f} !== 8'b11001100)
            $display("FAIL reset_other: got %b want 11001100",
                     {tx_o, ready_o, busy_o, done_o, tx_f, ready_f, busy_f, done_f});
        else n_pass++;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (tx_m !== 1'b1 || ready_m !== 1'b1)
            $display("FAIL reset_no_accept: got tx=%b ready=%b want 1 1", tx_m, ready_m);
        else n_pass++;
    endtask

    task automatic test_even_directed();
        send_frame(0, 4, 1'b0, 4'b1011);
        send_frame(0, 4, 1'b0, 4'b0000);
    endtask

    task automatic test_all_words();
        for (int w = 0; w < 16; w++) send_frame(0, 4, 1'b0, 4'(w));
    endtask

    task automatic test_odd();
        send_frame(1, 4, 1'b1, 4'b0110);
        for (int i = 0; i < 6; i++) send_frame(1, 4, 1'b1, 4'($urandom));
    endtask

    task automatic test_random_fast();
        for (int i = 0; i < 6; i++) send_frame(2, 1, 1'b0, 4'($urandom));
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] d;
        d = 4'b1011;
        sel = 0;
        @(negedge clk);
        drive(0, 1'b1, d);
        @(posedge clk);
        #1 drive(0, 1'b0, 4'($urandom));
        repeat (14) @(negedge clk);
        n_total++;
        if (tx_m !== d[2]) $display("FAIL mid_frame_bit2: got %b want %b", tx_m, d[2]);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({tx_m, ready_m, busy_m, done_m} !== 4'b1100)
            $display("FAIL mid_frame_reset: got tx,rdy,busy,done=%b want 1100",
                     {tx_m, ready_m, busy_m, done_m});
        else n_pass++;
        rst = 1'b0;
        send_frame(0, 4, 1'b0, 4'b0001);
    endtask

    task automatic test_back_to_back();
        logic [15:0] obs_tx, obs_done, obs_rdy, exp_tx, exp_done, exp_rdy;
        logic [6:0]  fa, fb;
        fa = model_frame(4'hA, 1'b0);
        fb = model_frame(4'h5, 1'b0);
        exp_tx   = {1'b1, fb, 1'b1, fa};
        exp_done = 16'b0100_0000_0100_0000;
        exp_rdy  = 16'b1000_0000_1000_0000;
        @(negedge clk);
        drive(2, 1'b1, 4'hA);
        @(posedge clk);
        #1 drive(2, 1'b1, 4'h5);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            obs_tx[k]   = tx_f;
            obs_done[k] = done_f;
            obs_rdy[k]  = ready_f;
            if (k == 8) drive(2, 1'b0, 4'h0);
        end
        n_total++;
        if (obs_tx !== exp_tx) $display("FAIL b2b_tx: got %h want %h", obs_tx, exp_tx);
        else n_pass++;
        n_total++;
        if (obs_done !== exp_done) $display("FAIL b2b_done: got %h want %h", obs_done, exp_done);
        else n_pass++;
        n_total++;
        if (obs_rdy !== exp_rdy) $display("FAIL b2b_ready: got %h want %h", obs_rdy, exp_rdy);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_even_directed();
        test_all_words();
        test_odd();
        test_random_fast();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
